// File: rtl/adc_pkt_pkg.sv
// Shared types for the ADC IQ packetizer: sample layout, FIFO word, FSM states.
package adc_pkt_pkg;

    typedef struct packed {
        logic signed [15:0] q;
        logic signed [15:0] i;
    } iq_sample_t;

    typedef struct packed {
        logic       last;
        iq_sample_t iq;
    } fifo_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } pkt_state_e;

    localparam logic [15:0] OVF_MAX = 16'hFFFF;
    localparam int          WORD_W  = $bits(fifo_word_t);

endpackage

// File: rtl/adc_iq_packetizer_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head word is presented whenever non-empty.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             rd_ok;
    logic             wr_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adc_iq_packetizer.sv
// Packs the unstoppable ADC IQ stream into fixed-length AXI-Stream packets with tlast;
// samples that find the FIFO full are dropped and counted.
module adc_iq_packetizer
    import adc_pkt_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int LEN_W      = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             enable,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic [31:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             busy,
    output logic [15:0]      ovf_count,
    output logic [31:0]      pkt_count
);
    pkt_state_e       state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] smp_cnt;
    logic [LEN_W-1:0] smp_cnt_nxt;
    logic             tready_q;
    logic             fifo_full;
    logic             fifo_empty;
    fifo_word_t       wr_word;
    fifo_word_t       rd_word;
    logic             attempt;
    logic             pop;
    logic             accept;
    logic             drop;
    logic             is_last;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == OVF_MAX) ? v : v + 16'd1;
    endfunction

    assign attempt     = s_axis_tvalid && (state != IDLE);
    assign pop         = m_axis_tvalid && m_axis_tready;
    assign accept      = attempt && (!fifo_full || pop);
    assign drop        = attempt && !accept;
    assign is_last     = (smp_cnt == len_q - LEN_W'(1));
    // Counter only moves on accepted samples so every packet carries exactly len_q samples.
    assign smp_cnt_nxt = !accept ? smp_cnt : (is_last ? '0 : smp_cnt + LEN_W'(1));
    assign wr_word     = {is_last, s_axis_tdata};

    sync_fifo #(
        .WIDTH(WORD_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (aclk),
        .rst    (areset),
        .wr_en  (attempt),
        .wr_data(wr_word),
        .rd_en  (m_axis_tready),
        .rd_data(rd_word),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = rd_word.iq;
    assign m_axis_tlast  = rd_word.last;
    assign s_axis_tready = tready_q;
    assign busy          = (state != IDLE);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            smp_cnt   <= '0;
            ovf_count <= '0;
            pkt_count <= '0;
            tready_q  <= 1'b0;
        end else begin
            tready_q <= 1'b1;
            if (drop) ovf_count <= sat_inc(ovf_count);
            if (accept && is_last) pkt_count <= pkt_count + 32'd1;
            case (state)
                IDLE: begin
                    if (enable && (pkt_len != '0)) begin
                        len_q   <= pkt_len;
                        smp_cnt <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    smp_cnt <= smp_cnt_nxt;
                    // Stopping on a packet boundary goes straight to IDLE; otherwise finish the packet.
                    if (!enable) state <= (smp_cnt_nxt == '0) ? IDLE : STOP;
                end
                STOP: begin
                    smp_cnt <= smp_cnt_nxt;
                    if (accept && is_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_iq_packetizer.sv
// Directed bench for adc_iq_packetizer: streaming, overflow, stop, reset and saturation cases.
module tb_adc_iq_packetizer;
    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] pkt_len = 16'd0;
    logic [31:0] s_axis_tdata = 32'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic        busy;
    logic [15:0] ovf_count;
    logic [31:0] pkt_count;

    int checks = 0;
    int errors = 0;
    logic [32:0] cap_q [$];

    adc_iq_packetizer dut (
        .aclk         (aclk),
        .areset       (areset),
        .enable       (enable),
        .pkt_len      (pkt_len),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .busy         (busy),
        .ovf_count    (ovf_count),
        .pkt_count    (pkt_count)
    );

    always #5 aclk = ~aclk;

    // Record every handshaken output beat, sampled mid-cycle.
    always @(negedge aclk) begin
        if (!areset && m_axis_tvalid && m_axis_tready)
            cap_q.push_back({m_axis_tlast, m_axis_tdata});
    end

    function automatic logic [31:0] iq(input int k);
        return {16'(-k), 16'(k)};
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = iq(k);
        step();
    endtask

    task automatic chk_stream(input string tag, input int base, input int n);
        chk({tag, "_len"}, 64'(cap_q.size()), 64'(n));
        for (int j = 0; j < n && j < cap_q.size(); j++)
            chk(tag, 64'(cap_q[j]), 64'({(j % 8 == 7), iq(base + j)}));
    endtask

    initial begin
        // Reset values
        step(); step(); step();
        chk("rst_tready", 64'(s_axis_tready), 64'(0));
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("rst_tlast", 64'(m_axis_tlast), 64'(0));
        chk("rst_tdata", 64'(m_axis_tdata), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ovf", 64'(ovf_count), 64'(0));
        chk("rst_pkt", 64'(pkt_count), 64'(0));
        areset = 1'b0;
        step();
        chk("tready_after_rst", 64'(s_axis_tready), 64'(1));

        // Three packets of 8, continuous stream, DMA always ready
        pkt_len = 16'd8; enable = 1'b1; m_axis_tready = 1'b1;
        step();
        chk("run_busy", 64'(busy), 64'(1));
        chk("run_tvalid0", 64'(m_axis_tvalid), 64'(0));
        for (int k = 0; k < 24; k++) begin
            push(k);
            if (k == 0) begin
                chk("lat_tvalid", 64'(m_axis_tvalid), 64'(1));
                chk("lat_tdata", 64'(m_axis_tdata), 64'(iq(0)));
                chk("lat_tlast", 64'(m_axis_tlast), 64'(0));
            end
        end
        s_axis_tvalid = 1'b0;
        step(); step(); step();
        chk("t1_pkt", 64'(pkt_count), 64'(3));
        chk("t1_ovf", 64'(ovf_count), 64'(0));
        chk_stream("t1_out", 0, 24);
        cap_q.delete();

        // Overflow: 70 beats into a stalled 64-deep FIFO
        m_axis_tready = 1'b0;
        for (int k = 0; k < 70; k++) push(100 + k);
        s_axis_tvalid = 1'b0;
        chk("t2_ovf", 64'(ovf_count), 64'(6));
        chk("t2_pkt", 64'(pkt_count), 64'(11));
        chk("t2_head", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 64'({2'b10, iq(100)}));
        step(); step();
        chk("t2_hold", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 64'({2'b10, iq(100)}));
        m_axis_tready = 1'b1;
        for (int k = 0; k < 70; k++) step();
        chk("t2_ovf_after", 64'(ovf_count), 64'(6));
        chk_stream("t2_out", 100, 64);
        cap_q.delete();

        // Full FIFO with simultaneous push and pop every cycle
        m_axis_tready = 1'b0;
        for (int k = 0; k < 64; k++) push(200 + k);
        chk("t4_fill_ovf", 64'(ovf_count), 64'(6));
        m_axis_tready = 1'b1;
        for (int k = 0; k < 98; k++) push(264 + k);
        s_axis_tvalid = 1'b0;
        chk("t4_ovf", 64'(ovf_count), 64'(6));
        chk("t4_pops", 64'(cap_q.size()), 64'(98));
        for (int k = 0; k < 80; k++) step();
        chk_stream("t4_out", 200, 162);
        chk("t4_pkt", 64'(pkt_count), 64'(31));
        cap_q.delete();

        // Reset mid-packet (4 of 8) with 10 words queued
        m_axis_tready = 1'b0;
        for (int k = 0; k < 10; k++) push(500 + k);
        s_axis_tvalid = 1'b0;
        chk("t5_pkt_pre", 64'(pkt_count), 64'(32));
        chk("t5_tvalid_pre", 64'(m_axis_tvalid), 64'(1));
        areset = 1'b1;
        step();
        chk("t5_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("t5_tdata", 64'(m_axis_tdata), 64'(0));
        chk("t5_busy", 64'(busy), 64'(0));
        chk("t5_pkt", 64'(pkt_count), 64'(0));
        chk("t5_ovf", 64'(ovf_count), 64'(0));
        areset = 1'b0;
        step();
        chk("t5_busy_restart", 64'(busy), 64'(1));
        chk("t5_tvalid_restart", 64'(m_axis_tvalid), 64'(0));
        m_axis_tready = 1'b1;
        for (int k = 0; k < 8; k++) push(600 + k);
        s_axis_tvalid = 1'b0;
        step(); step(); step();
        chk_stream("t5_out", 600, 8);
        chk("t5_pkt_restart", 64'(pkt_count), 64'(1));
        cap_q.delete();

        // Disable after 3 samples: packet completes, then IDLE
        for (int k = 0; k < 3; k++) push(700 + k);
        enable = 1'b0;
        for (int k = 3; k < 8; k++) begin
            push(700 + k);
            chk("t3_busy", 64'(busy), 64'(k < 7));
        end
        for (int k = 0; k < 4; k++) push(800 + k);
        s_axis_tvalid = 1'b0;
        step(); step(); step();
        chk_stream("t3_out", 700, 8);
        chk("t3_ovf", 64'(ovf_count), 64'(0));
        chk("t3_pkt", 64'(pkt_count), 64'(2));
        cap_q.delete();

        // pkt_len = 0 keeps IDLE; then saturate the overflow counter
        pkt_len = 16'd0; enable = 1'b1;
        for (int k = 0; k < 3; k++) push(900 + k);
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("t6_ovf_idle", 64'(ovf_count), 64'(0));
        s_axis_tvalid = 1'b0;
        pkt_len = 16'd8;
        step();
        chk("t6_busy_run", 64'(busy), 64'(1));
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = iq(1000);
        for (int k = 0; k < 64 + 65535; k++) step();
        chk("t6_ovf_max", 64'(ovf_count), 64'(16'hFFFF));
        chk("t6_pkt", 64'(pkt_count), 64'(10));
        for (int k = 0; k < 70000 - 65535; k++) step();
        s_axis_tvalid = 1'b0;
        chk("t6_ovf_sat", 64'(ovf_count), 64'(16'hFFFF));
        chk("t6_out", 64'(cap_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
